// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer: decodes one captured instruction into datapath controls.
// Optional feature macro: DPSEQ_ILLEGAL_TRAP_EN adds the `illegal` output flag.
module datapath_sequencer #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] instr,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
`ifdef DPSEQ_ILLEGAL_TRAP_EN
    output logic          illegal,
`endif
    output logic [DW-1:0] datapath_in
);

    typedef enum logic [2:0] {
        IDLE, DECODE, WRITE_IMM, LOAD_A, LOAD_B, EXEC, WRITE_C, DONE
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] ir;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic          is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_legal;

    assign opcode     = ir[15:13];
    assign op         = ir[12:11];
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start)
                ir <= instr;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start) state_nx = DECODE;
            DECODE: begin
                // Unsupported encodings fall straight through to DONE with no side effects.
                if (is_mov_imm)                  state_nx = WRITE_IMM;
                else if (is_mov_reg || is_mvn)   state_nx = LOAD_B;
                else if (is_alu)                 state_nx = LOAD_A;
                else                             state_nx = DONE;
            end
            WRITE_IMM: state_nx = DONE;
            LOAD_A:    state_nx = LOAD_B;
            LOAD_B:    state_nx = EXEC;
            EXEC:      state_nx = is_cmp ? DONE : WRITE_C;
            WRITE_C:   state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        readnum     = '0;
        writenum    = '0;
        write       = 1'b0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = 2'b00;
        ALUop       = 2'b00;
        datapath_in = '0;
        unique case (state)
            WRITE_IMM: begin
                writenum    = ir[10:8];
                write       = 1'b1;
                vsel        = 1'b1;
                datapath_in = {{(DW-8){ir[7]}}, ir[7:0]};
            end
            LOAD_A: begin
                readnum = ir[10:8];
                loada   = 1'b1;
            end
            LOAD_B: begin
                readnum = ir[2:0];
                loadb   = 1'b1;
            end
            EXEC: begin
                shift = ir[4:3];
                ALUop = op;
                // MOV-reg rides the ADD path with A forced to zero.
                asel  = is_mov_reg;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            WRITE_C: begin
                writenum = ir[7:5];
                write    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef DPSEQ_ILLEGAL_TRAP_EN
    assign illegal = (state == DONE) && !is_legal;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: expected per-cycle control vectors are queued
// from the instruction path table when start is driven, then popped one per clock.
module tb_datapath_sequencer;

    typedef struct packed {
        logic        busy, done;
        logic [2:0]  readnum, writenum;
        logic        write, vsel, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  shift, aluop;
        logic [15:0] dp;
        logic        illegal;
    } ctl_t;

    typedef enum int { S_IDLE, S_DEC, S_WIMM, S_LA, S_LB, S_EX, S_WC, S_DONE } step_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] instr = '0;
    logic        busy, done, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        illegal_w;

    int   checks = 0, passed = 0;
    ctl_t sb[$];

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .busy(busy), .done(done), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop),
`ifdef DPSEQ_ILLEGAL_TRAP_EN
        .illegal(illegal_w),
`endif
        .datapath_in(datapath_in)
    );

`ifndef DPSEQ_ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t c;
        c = '{busy: busy, done: done, readnum: readnum, writenum: writenum,
              write: write, vsel: vsel, loada: loada, loadb: loadb, loadc: loadc,
              loads: loads, asel: asel, bsel: bsel, shift: shift, aluop: ALUop,
              dp: datapath_in, illegal: illegal_w};
        return c;
    endfunction

    function automatic ctl_t expect_ctl(step_t s, logic [15:0] in);
        ctl_t c;
        logic [2:0] opc;
        logic [1:0] op;
        opc = in[15:13];
        op  = in[12:11];
        c = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_WIMM: begin c.writenum = in[10:8]; c.write = 1; c.vsel = 1;
                          c.dp = {{8{in[7]}}, in[7:0]}; end
            S_LA:   begin c.readnum = in[10:8]; c.loada = 1; end
            S_LB:   begin c.readnum = in[2:0];  c.loadb = 1; end
            S_EX:   begin c.shift = in[4:3]; c.aluop = op;
                          c.asel  = (opc == 3'b110);
                          c.loadc = !(op == 2'b01);
                          c.loads = (op == 2'b01); end
            S_WC:   begin c.writenum = in[7:5]; c.write = 1; end
            S_DONE: begin c.done = 1;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
                          c.illegal = !((opc == 3'b101) ||
                                        (opc == 3'b110 && (op == 2'b00 || op == 2'b10)));
`endif
                    end
            default: ;
        endcase
        return c;
    endfunction

    // Path table: which steps each encoding walks through after the start edge.
    task automatic push_path(input logic [15:0] in);
        step_t p[$];
        logic [2:0] opc;
        logic [1:0] op;
        opc = in[15:13];
        op  = in[12:11];
        if (opc == 3'b110 && op == 2'b10)      p = '{S_DEC, S_WIMM, S_DONE};
        else if (opc == 3'b110 && op == 2'b00) p = '{S_DEC, S_LB, S_EX, S_WC, S_DONE};
        else if (opc == 3'b101 && op == 2'b01) p = '{S_DEC, S_LA, S_LB, S_EX, S_DONE};
        else if (opc == 3'b101 && op == 2'b11) p = '{S_DEC, S_LB, S_EX, S_WC, S_DONE};
        else if (opc == 3'b101)                p = '{S_DEC, S_LA, S_LB, S_EX, S_WC, S_DONE};
        else                                   p = '{S_DEC, S_DONE};
        foreach (p[i]) sb.push_back(expect_ctl(p[i], in));
        sb.push_back(expect_ctl(S_IDLE, in));
    endtask

    // One start pulse; optionally a stray start pulse (with another instr) at cycle pulse_cyc.
    task automatic run_instr(input string name, input logic [15:0] in,
                             input int pulse_cyc, input logic [15:0] pulse_in);
        int cyc;
        ctl_t act, exp_c;
        @(negedge clk);
        instr = in;
        start = 1'b1;
        push_path(in);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin start = 1'b0; instr = ~in; end
            if (cyc == pulse_cyc) begin start = 1'b1; instr = pulse_in; end
            else if (pulse_cyc > 0 && cyc == pulse_cyc + 1) start = 1'b0;
            exp_c = sb.pop_front();
            act   = sample();
            checks++;
            if (act !== exp_c)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp_c);
            else passed++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t act;
        #1;
        act = sample();
        checks++;
        if (act !== ctl_t'(0)) $display("FAIL reset_state: got %h expected 0", act);
        else passed++;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mov_imm();
        run_instr("mov_r0_50",   16'hD032, 0, 16'h0);
        run_instr("mov_r1_neg3", 16'hD1FD, 0, 16'h0);
    endtask

    task automatic test_alu();
        run_instr("add_r2_r0_r1", 16'hA041, 0, 16'h0);
        run_instr("cmp_r0_r1",    16'hA801, 0, 16'h0);
        run_instr("and_r7_r3_r6", 16'hB3FE, 0, 16'h0);
        run_instr("mvn_r3_r2",    16'hB872, 0, 16'h0);
        run_instr("mov_r4_r5",    16'hC08D, 0, 16'h0);
    endtask

    task automatic test_reset_mid();
        ctl_t act, exp_c;
        @(negedge clk);
        instr = 16'hA041;
        start = 1'b1;
        push_path(16'hA041);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_c = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp_c) $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", c, act, exp_c);
            else passed++;
        end
        sb.delete();
        #2 reset = 1'b1;
        #1;
        act = sample();
        checks++;
        if (act !== ctl_t'(0)) $display("FAIL reset_mid_async: got %h expected 0", act);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            act = sample();
            checks++;
            if (act.write !== 1'b0 || act.done !== 1'b0 || act.busy !== 1'b0)
                $display("FAIL reset_mid_quiet cycle %0d: got %h expected idle", c, act);
            else passed++;
        end
        run_instr("mov_after_reset", 16'hD032, 0, 16'h0);
    endtask

    task automatic test_start_ignored();
        run_instr("add_stray_start", 16'hA041, 4, 16'hD032);
    endtask

    task automatic test_back_to_back();
        int cyc;
        ctl_t act, exp_c;
        @(negedge clk);
        instr = 16'hD032;
        start = 1'b1;
        push_path(16'hD032);
        push_path(16'hD1FD);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) instr = 16'hD1FD;
            if (cyc == 5) start = 1'b0;
            exp_c = sb.pop_front();
            act = sample();
            checks++;
            if (act !== exp_c) $display("FAIL back_to_back cycle %0d: got %h expected %h", cyc, act, exp_c);
            else passed++;
        end
        start = 1'b0;
    endtask

    task automatic test_unsupported();
        run_instr("nop_0000", 16'h0000, 0, 16'h0);
        run_instr("nop_c800", 16'hC800, 0, 16'h0);
        run_instr("nop_f000", 16'hF000, 0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_alu();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_unsupported();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
